// File: rtl/source_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : source_mul_pkg
// Description : Shared constants and helpers for the source_mul array
//               multiplier: default operand width and product-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package source_mul_pkg;

    // Default operand width of the multiplier (2x2 -> 4-bit product)
    localparam int c_default_width = 2;

    // Full product width for a given operand width; never truncates
    function automatic int prod_w(input int width);
        return 2 * width;
    endfunction

endpackage : source_mul_pkg
`default_nettype wire

// File: rtl/source_fa.sv
`default_nettype none
// ============================================================================
// Module      : source_fa
// Description : Single-bit full adder, the cell of the multiplier array.
// Ports       : a, b, cin  - addend bits and carry in
//               s          - sum bit
//               cout       - carry out
// Revision    : 1.0 - initial release
// ============================================================================
module source_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_axb;

    assign w_axb = a ^ b;
    assign s     = w_axb ^ cin;
    assign cout  = (a & b) | (cin & w_axb);

endmodule : source_fa
`default_nettype wire

// File: rtl/source_mul2x2.sv
`default_nettype none
// ============================================================================
// Module      : source_mul2x2
// Description : Registered unsigned array multiplier, y = a * b. The product
//               is formed combinationally from an AND plane of partial
//               products summed through ripple rows of full adders; only the
//               output product and its valid flag are registered.
// Ports       : clk       - rising-edge clock
//               rst_n     - synchronous active-low reset
//               in_valid  - operands valid, capture product on this edge
//               a, b      - unsigned operands, WIDTH bits
//               y         - registered product, 2*WIDTH bits
//               out_valid - y was updated on the preceding edge
// Revision    : 1.0 - initial release
// ============================================================================
module source_mul2x2
    import source_mul_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    output logic [prod_w(WIDTH)-1:0] y,
    output logic                     out_valid
);

    localparam int PROD_W = prod_w(WIDTH);

    // Partial products: w_pp[i] = a & {WIDTH{b[i]}}
    logic [WIDTH-1:0]  w_pp  [WIDTH];
    // Running sum after adding row i; row i spans bits 0 .. i+WIDTH,
    // anything above that is zero
    logic [PROD_W-1:0] w_acc [WIDTH];

    logic [PROD_W-1:0] r_y;
    logic              r_out_valid;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_pp
            assign w_pp[i] = a & {WIDTH{b[i]}};
        end
    endgenerate

    // Row 0 is the bare first partial product
    assign w_acc[0] = PROD_W'(w_pp[0]);

    // Row i adds pp[i] to bits [i +: WIDTH] of the previous running sum.
    // The low i bits are already final and pass straight through; the row's
    // carry out becomes the new top bit.
    generate
        for (genvar i = 1; i < WIDTH; i++) begin : g_row
            logic [WIDTH-1:0] w_s;
            logic [WIDTH:0]   w_c;

            assign w_c[0] = 1'b0;

            for (genvar j = 0; j < WIDTH; j++) begin : g_col
                source_fa u_fa (
                    .a    (w_acc[i-1][i+j]),
                    .b    (w_pp[i][j]),
                    .cin  (w_c[j]),
                    .s    (w_s[j]),
                    .cout (w_c[j+1])
                );
            end

            assign w_acc[i] = PROD_W'({w_c[WIDTH], w_s, w_acc[i-1][i-1:0]});
        end
    endgenerate

    // Output stage: reset wins over capture; y only loads on in_valid so
    // unknown operands during idle cycles never reach the register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else if (in_valid) begin
            r_y         <= w_acc[WIDTH-1];
            r_out_valid <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign y         = r_y;
    assign out_valid = r_out_valid;

endmodule : source_mul2x2
`default_nettype wire

// File: tb/tb_source_mul2x2.sv
`default_nettype none
// ============================================================================
// Module      : tb_source_mul2x2
// Description : Self-checking bench for source_mul2x2 at WIDTH=2 (directed
//               and exhaustive) and WIDTH=4 (random plus max operands).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_source_mul2x2;

    typedef struct packed {
        logic [3:0] y;
        logic       v;
    } exp2_t;

    typedef struct packed {
        logic [7:0] y;
        logic       v;
    } exp4_t;

    logic       clk;
    logic       rst_n2, iv2, ov2;
    logic [1:0] a2, b2;
    logic [3:0] y2;
    logic       rst_n4, iv4, ov4;
    logic [3:0] a4, b4;
    logic [7:0] y4;

    exp2_t q2 [$];
    exp4_t q4 [$];

    // Reference state: what y/out_valid must hold after the next edge
    logic [3:0] m2_y;
    logic       m2_v;
    logic [7:0] m4_y;
    logic       m4_v;

    int checks = 0;
    int errors = 0;

    source_mul2x2 #(.WIDTH(2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n2),
        .in_valid  (iv2),
        .a         (a2),
        .b         (b2),
        .y         (y2),
        .out_valid (ov2)
    );

    source_mul2x2 #(.WIDTH(4)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n4),
        .in_valid  (iv4),
        .a         (a4),
        .b         (b4),
        .y         (y4),
        .out_valid (ov4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check2(input string tag);
        exp2_t e;
        if (q2.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed y=%0d", tag, y2);
            return;
        end
        e = q2.pop_front();
        checks++;
        assert (y2 === e.y) else begin
            errors++;
            $error("FAIL %s y: observed %0d expected %0d", tag, y2, e.y);
        end
        checks++;
        assert (ov2 === e.v) else begin
            errors++;
            $error("FAIL %s out_valid: observed %0b expected %0b", tag, ov2, e.v);
        end
    endtask

    task automatic step2(input logic rn, input logic iv, input logic [1:0] ta,
                         input logic [1:0] tb_in, input string tag);
        rst_n2 = rn;
        iv2    = iv;
        a2     = ta;
        b2     = tb_in;
        if (!rn) begin
            m2_y = '0;
            m2_v = 1'b0;
        end else if (iv) begin
            m2_y = 4'(ta) * 4'(tb_in);
            m2_v = 1'b1;
        end else begin
            m2_v = 1'b0;
        end
        q2.push_back({m2_y, m2_v});
        @(posedge clk);
        #1;
        check2(tag);
    endtask

    task automatic check4(input string tag);
        exp4_t e;
        if (q4.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty, observed y=%0d", tag, y4);
            return;
        end
        e = q4.pop_front();
        checks++;
        assert (y4 === e.y) else begin
            errors++;
            $error("FAIL %s y: observed %0d expected %0d", tag, y4, e.y);
        end
        checks++;
        assert (ov4 === e.v) else begin
            errors++;
            $error("FAIL %s out_valid: observed %0b expected %0b", tag, ov4, e.v);
        end
    endtask

    task automatic step4(input logic rn, input logic iv, input logic [3:0] ta,
                         input logic [3:0] tb_in, input string tag);
        rst_n4 = rn;
        iv4    = iv;
        a4     = ta;
        b4     = tb_in;
        if (!rn) begin
            m4_y = '0;
            m4_v = 1'b0;
        end else if (iv) begin
            m4_y = 8'(ta) * 8'(tb_in);
            m4_v = 1'b1;
        end else begin
            m4_v = 1'b0;
        end
        q4.push_back({m4_y, m4_v});
        @(posedge clk);
        #1;
        check4(tag);
    endtask

    initial begin
        logic [1:0] xx;
        m2_y   = '0;
        m2_v   = 1'b0;
        m4_y   = '0;
        m4_v   = 1'b0;
        rst_n2 = 1'b0;
        iv2    = 1'b0;
        a2     = '0;
        b2     = '0;
        rst_n4 = 1'b0;
        iv4    = 1'b0;
        a4     = '0;
        b4     = '0;
        xx     = 2'bxx;

        // Reset state of the 2-bit multiplier
        step2(1'b0, 1'b0, 2'd0, 2'd0, "reset2");
        step2(1'b0, 1'b0, 2'd0, 2'd0, "reset2");

        // Exhaustive 2x2, one product per cycle
        for (int i = 0; i < 16; i++) begin
            step2(1'b1, 1'b1, 2'(i >> 2), 2'(i), "exhaustive");
        end

        // Zero operands
        step2(1'b1, 1'b1, 2'd0, 2'd3, "zero_a");
        step2(1'b1, 1'b1, 2'd3, 2'd0, "zero_b");

        // Hold: y stays at 6 while in_valid is low
        step2(1'b1, 1'b1, 2'd3, 2'd2, "hold_capture");
        for (int i = 0; i < 3; i++) begin
            step2(1'b1, 1'b0, 2'd1, 2'd1, "hold");
        end

        // Unknown operands while idle must not disturb y
        step2(1'b1, 1'b0, xx, xx, "x_idle");

        // Reset has priority over a pending capture
        step2(1'b1, 1'b1, 2'd3, 2'd3, "pre_reset");
        step2(1'b0, 1'b1, 2'd2, 2'd2, "mid_reset");
        step2(1'b1, 1'b1, 2'd2, 2'd2, "post_reset");

        // Back-to-back products
        step2(1'b1, 1'b1, 2'd1, 2'd1, "b2b_1");
        step2(1'b1, 1'b1, 2'd2, 2'd1, "b2b_2");
        step2(1'b1, 1'b1, 2'd3, 2'd2, "b2b_3");
        step2(1'b1, 1'b0, 2'd0, 2'd0, "b2b_end");

        // 4-bit multiplier: reset state, random run, max operands
        step4(1'b0, 1'b1, 4'd5, 4'd5, "reset4");
        for (int i = 0; i < 1000; i++) begin
            step4(1'b1, ($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom),
                  "random4");
        end
        step4(1'b1, 1'b1, 4'd15, 4'd15, "max4");
        step4(1'b1, 1'b1, 4'd0, 4'd15, "zero4");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_source_mul2x2
`default_nettype wire
